bram24_arb: RTL and testbench
=============================

Name: bram24_arb

Overview:
- Round-robin arbiter that shares one 24-bit x 1024-entry synchronous block RAM between NREQ requesters, for example a CPU port and a video/DMA port.
- Sits between the requesters and the RAM's separate read and write ports.
- Issues at most one access per cycle, either a read or a write.
- Returns read data to the requester that issued the read, one cycle after the read is accepted.

Parameters:
- NREQ, 2: number of requesters, legal range 2..4.
- ADDR_W, 10: address width, which gives a 1024-word depth.
- DATA_W, 24: data width, matching three 8-bit RAM lanes.

Ports:
- clk  in  1  system clock; all logic acts on its rising edge.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  NREQ  per-requester request strobe.
- req_ready  out  NREQ  per-requester accept; the request is accepted in a cycle where valid=1 and ready=1.
- req_we  in  NREQ  1 = write, 0 = read.
- req_addr  in  NREQ*ADDR_W  packed addresses; requester i uses bits [i*ADDR_W +: ADDR_W].
- req_wdata  in  NREQ*DATA_W  packed write data.
- rsp_valid  out  NREQ  one-cycle pulse when read data is valid for requester i.
- rsp_data  out  DATA_W  read data, shared by all requesters; qualified by rsp_valid.
- mem_rd_en  out  1  RAM read enable.
- mem_rd_addr  out  ADDR_W  RAM read address.
- mem_rd_data  in  DATA_W  RAM registered read data; valid the cycle after mem_rd_en, held while mem_rd_en=0.
- mem_wr_en  out  1  RAM write enable.
- mem_wr_addr  out  ADDR_W  RAM write address.
- mem_wr_data  out  DATA_W  RAM write data.

Behaviour:
- Reset: synchronous, active-high, on clk.
  - last_grant <= NREQ-1, so requester 0 wins first.
  - rsp_valid <= 0 and the response-owner register <= 0.
  - While rst=1: req_ready=0, mem_rd_en=0, mem_wr_en=0, and no request is accepted.
- Arbitration is combinational within a cycle.
  - Among requesters with req_valid=1, grant the first one found scanning from last_grant+1 upward, modulo NREQ.
  - Exactly one req_ready bit is high when any valid is present; all are low otherwise.
  - req_ready does not depend on any other requester's ready; there is no wait state and no backpressure.
- On acceptance of requester g:
  - last_grant <= g on the next edge.
  - If req_we[g]=1: mem_wr_en=1, mem_wr_addr and mem_wr_data come from requester g, mem_rd_en=0.
  - If req_we[g]=0: mem_rd_en=1, mem_rd_addr comes from requester g, mem_wr_en=0.
- Address and data outputs are don't-care when their enable is 0.
  - Drive them from the granted requester anyway, to minimise muxing.
- Read latency is exactly 1.
  - A read accepted in cycle N gives rsp_valid[g]=1 in cycle N+1, with rsp_data = mem_rd_data, which is passed through combinationally.
  - The owner is registered at cycle N.
  - Back-to-back reads from any mix of requesters deliver one response per cycle, in acceptance order.
- Writes produce no response.
  - A write accepted in cycle N is visible to a read accepted in cycle N+1 or later.
- Requesters hold valid, we, addr and wdata stable until accepted.
  - The arbiter does not latch unaccepted requests.
- Fairness: a requester that holds valid is granted within NREQ cycles.
  - With every requester continuously valid, the grant sequence is 0,1,...,NREQ-1,0,...
- A single active requester is granted every cycle, giving 100% throughput.
- Reset asserted in cycle N+1 after a read accepted in cycle N:
  - That response is dropped, so rsp_valid stays 0.
  - The RAM contents are unaffected by reset.
- rsp_valid is one-hot or zero; it is never multi-hot.

Decomposition:
- Package bram24_arb_pkg holds ADDR_W=10, DATA_W=24, the maximum NREQ=4, and the grant-index width function clog2(NREQ).
- Sub-module rr_arbiter (NREQ-parameterised) contains:
  - inputs req[NREQ-1:0] and advance;
  - outputs grant_onehot and grant_idx;
  - the internal last_grant register, with the same reset rules.
- The top level holds the datapath muxes and the response-owner pipeline register.
- The RAM itself is instantiated by the parent, not inside this block.

Test Plan:
- Reset priority: reset, then both requesters valid with reads to 0x005 and 0x00A on a preloaded RAM.
  - Grants come in cycles 1 and 2 (0 first, then 1).
  - rsp_valid=01 with rsp_data=0x050505, then rsp_valid=10 with rsp_data=0x0A0A0A.
- Write then read: requester 0 writes 0x123456 to 0x3FF, then reads 0x3FF on the next cycle.
  - rsp_valid[0] pulses two cycles after the write, with data 0x123456.
  - No rsp_valid pulse follows the write.
- Fairness under saturation: both requesters valid for 20 cycles with mixed read/write.
  - The grant alternates 0,1,0,1 with no gaps.
  - Each read response arrives exactly 1 cycle later, tagged to the correct requester.
- Single requester: only requester 1 is valid, reading 0x000..0x007 on consecutive cycles.
  - Eight consecutive rsp_valid[1] pulses in address order, with no idle cycles.
- Reset mid-operation: a read is accepted in cycle N and rst=1 in cycle N+1.
  - rsp_valid=0 in cycle N+1.
  - After release, requester 0 wins first.
- Idle and hold: no valid for 5 cycles gives mem_rd_en=mem_wr_en=0 and rsp_data held stable.
  - Then a request appears and is granted the same cycle.

Source files
------------

// File: rtl/bram24_arb_pkg.sv
// Shared constants and helpers for the 24-bit block RAM arbiter.
package bram24_arb_pkg;

  localparam int ADDR_W   = 10;
  localparam int DATA_W   = 24;
  localparam int NREQ_MAX = 4;

  // Width of a grant index; never narrower than one bit.
  function automatic int clog2(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/bram24_arb_if.sv
// Requester-side bus of the arbiter: request handshake plus shared read response.
interface bram24_arb_if
  import bram24_arb_pkg::*;
#(
  parameter int NREQ = 2
);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ-1:0]        req_we;
  logic [NREQ*ADDR_W-1:0] req_addr;
  logic [NREQ*DATA_W-1:0] req_wdata;
  logic [NREQ-1:0]        rsp_valid;
  logic [DATA_W-1:0]      rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/bram24_arb_rr_arbiter.sv
// Round-robin arbiter: combinational grant, scanning upward from the last winner.
module rr_arbiter
  import bram24_arb_pkg::*;
#(
  parameter int NREQ  = 2,
  parameter int IDX_W = clog2(NREQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req,
  input  logic             advance,
  output logic [NREQ-1:0]  grant_onehot,
  output logic [IDX_W-1:0] grant_idx
);

  logic [IDX_W-1:0] last_grant_q, last_grant_d;
  logic [IDX_W:0]   cand;
  logic             found;

  // Extra bit on cand holds last_grant + i before the modulo wrap.
  always_comb begin
    grant_onehot = '0;
    grant_idx    = '0;
    cand         = '0;
    found        = 1'b0;
    if (!rst) begin
      for (int i = 1; i <= NREQ; i++) begin
        cand = {1'b0, last_grant_q} + (IDX_W+1)'(i);
        if (cand >= (IDX_W+1)'(NREQ)) cand = cand - (IDX_W+1)'(NREQ);
        if (!found && req[cand[IDX_W-1:0]]) begin
          found                           = 1'b1;
          grant_idx                       = cand[IDX_W-1:0];
          grant_onehot[cand[IDX_W-1:0]]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    last_grant_d = advance ? grant_idx : last_grant_q;
  end

  always_ff @(posedge clk) begin
    if (rst) last_grant_q <= IDX_W'(NREQ-1);
    else     last_grant_q <= last_grant_d;
  end

endmodule

// File: rtl/bram24_arb.sv
// Shares one 24-bit x 1024 synchronous RAM between NREQ requesters, one access per cycle.
module bram24_arb
  import bram24_arb_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic              clk,
  input  logic              rst,
  bram24_arb_if.slave       bus,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [DATA_W-1:0] mem_wr_data
);

  localparam int IDX_W = clog2(NREQ);

  logic [NREQ-1:0]   grant_onehot;
  logic [IDX_W-1:0]  grant_idx;
  logic              accept;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;

  logic              rsp_pend_q, rsp_pend_d;
  logic [IDX_W-1:0]  rsp_owner_q, rsp_owner_d;

  rr_arbiter #(.NREQ(NREQ), .IDX_W(IDX_W)) u_rr_arbiter (
    .clk          (clk),
    .rst          (rst),
    .req          (bus.req_valid),
    .advance      (accept),
    .grant_onehot (grant_onehot),
    .grant_idx    (grant_idx)
  );

  // Address/data always follow the winner; only the enables are qualified.
  always_comb begin
    accept        = |grant_onehot;
    sel_we        = bus.req_we[grant_idx];
    sel_addr      = bus.req_addr[int'(grant_idx)*ADDR_W +: ADDR_W];
    sel_wdata     = bus.req_wdata[int'(grant_idx)*DATA_W +: DATA_W];
    bus.req_ready = grant_onehot;
    mem_rd_en     = accept && !sel_we;
    mem_wr_en     = accept && sel_we;
    mem_rd_addr   = sel_addr;
    mem_wr_addr   = sel_addr;
    mem_wr_data   = sel_wdata;
  end

  always_comb begin
    rsp_pend_d  = mem_rd_en;
    rsp_owner_d = mem_rd_en ? grant_idx : rsp_owner_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_pend_q  <= 1'b0;
      rsp_owner_q <= '0;
    end else begin
      rsp_pend_q  <= rsp_pend_d;
      rsp_owner_q <= rsp_owner_d;
    end
  end

  // Gating with rst drops a response whose read was accepted just before reset.
  always_comb begin
    bus.rsp_valid = '0;
    if (rsp_pend_q && !rst) bus.rsp_valid[rsp_owner_q] = 1'b1;
    bus.rsp_data = mem_rd_data;
  end

endmodule

// File: tb/tb_bram24_arb.sv
// Directed bench for bram24_arb with a behavioural synchronous RAM preloaded as {3{addr[7:0]}}.
module tb_bram24_arb;
  import bram24_arb_pkg::*;

  localparam int NREQ = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  bram24_arb_if #(.NREQ(NREQ)) bus ();

  logic              mem_rd_en, mem_wr_en;
  logic [ADDR_W-1:0] mem_rd_addr, mem_wr_addr;
  logic [DATA_W-1:0] mem_rd_data, mem_wr_data;
  logic [DATA_W-1:0] ram [1024];

  int checks   = 0;
  int failures = 0;

  bram24_arb #(.NREQ(NREQ)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .mem_rd_en   (mem_rd_en),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .mem_wr_en   (mem_wr_en),
    .mem_wr_addr (mem_wr_addr),
    .mem_wr_data (mem_wr_data)
  );

  // Registered-output RAM; read data holds while mem_rd_en is low.
  always @(posedge clk) begin
    if (mem_wr_en) ram[mem_wr_addr] <= mem_wr_data;
    if (mem_rd_en) mem_rd_data <= ram[mem_rd_addr];
  end

  function automatic logic [23:0] pat(input logic [9:0] a);
    return {3{a[7:0]}};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic [1:0] v, input logic [1:0] we,
                               input logic [9:0] a0, input logic [9:0] a1,
                               input logic [23:0] d0, input logic [23:0] d1);
    @(posedge clk);
    #1;
    rst           = r;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = {a1, a0};
    bus.req_wdata = {d1, d0};
    #2;
  endtask

  logic [9:0]  a0, a1, gaddr;
  logic        we0, we1, gwe, prev_rd;
  int          j0, j1, g, prev_owner;
  logic [23:0] prev_data;

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = pat(10'(i));
    bus.req_valid = '0;
    bus.req_we    = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;

    // Reset with both requesters asking: nothing accepted
    applyStimulus(1'b1, 2'b11, 2'b00, 10'h005, 10'h00A, 24'h0, 24'h0);
    applyStimulus(1'b1, 2'b11, 2'b00, 10'h005, 10'h00A, 24'h0, 24'h0);
    checkOutput("rst_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("rst_rd_en", 32'(mem_rd_en), 32'h0);
    checkOutput("rst_wr_en", 32'(mem_wr_en), 32'h0);
    checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);

    // Reset priority: requester 0 first, then 1
    applyStimulus(1'b0, 2'b11, 2'b00, 10'h005, 10'h00A, 24'h0, 24'h0);
    checkOutput("prio_ready0", 32'(bus.req_ready), 32'h1);
    checkOutput("prio_rd_en0", 32'(mem_rd_en), 32'h1);
    checkOutput("prio_rd_addr0", 32'(mem_rd_addr), 32'h005);
    applyStimulus(1'b0, 2'b10, 2'b00, 10'h005, 10'h00A, 24'h0, 24'h0);
    checkOutput("prio_ready1", 32'(bus.req_ready), 32'h2);
    checkOutput("prio_rd_addr1", 32'(mem_rd_addr), 32'h00A);
    checkOutput("prio_rsp_valid0", 32'(bus.rsp_valid), 32'h1);
    checkOutput("prio_rsp_data0", 32'(bus.rsp_data), 32'h050505);
    applyStimulus(1'b0, 2'b00, 2'b00, 10'h0, 10'h0, 24'h0, 24'h0);
    checkOutput("prio_rsp_valid1", 32'(bus.rsp_valid), 32'h2);
    checkOutput("prio_rsp_data1", 32'(bus.rsp_data), 32'h0A0A0A);
    checkOutput("prio_idle_rd_en", 32'(mem_rd_en), 32'h0);

    // Write then read the same address
    applyStimulus(1'b0, 2'b01, 2'b01, 10'h3FF, 10'h0, 24'h123456, 24'h0);
    checkOutput("wr_ready", 32'(bus.req_ready), 32'h1);
    checkOutput("wr_en", 32'(mem_wr_en), 32'h1);
    checkOutput("wr_rd_en", 32'(mem_rd_en), 32'h0);
    checkOutput("wr_addr", 32'(mem_wr_addr), 32'h3FF);
    checkOutput("wr_data", 32'(mem_wr_data), 32'h123456);
    applyStimulus(1'b0, 2'b01, 2'b00, 10'h3FF, 10'h0, 24'h0, 24'h0);
    checkOutput("wr_no_rsp", 32'(bus.rsp_valid), 32'h0);
    checkOutput("rbw_rd_en", 32'(mem_rd_en), 32'h1);
    applyStimulus(1'b0, 2'b00, 2'b00, 10'h0, 10'h0, 24'h0, 24'h0);
    checkOutput("rbw_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("rbw_rsp_data", 32'(bus.rsp_data), 32'h123456);

    // Saturation: last winner was 0, so grants run 1,0,1,0,...
    prev_rd = 1'b0;
    prev_owner = 0;
    prev_data = '0;
    for (int k = 0; k < 20; k++) begin
      j0  = k / 2;
      j1  = (k + 1) / 2;
      a0  = 10'h140 + 10'(j0);
      a1  = 10'h280 + 10'(j1);
      we0 = j0[0];
      we1 = j1[0];
      applyStimulus(1'b0, 2'b11, {we1, we0}, a0, a1, 24'hA00000 + 24'(k), 24'hB00000 + 24'(k));
      g = (k % 2 == 0) ? 1 : 0;
      checkOutput("sat_ready", 32'(bus.req_ready), (g == 1) ? 32'h2 : 32'h1);
      if (prev_rd) begin
        checkOutput("sat_rsp_valid", 32'(bus.rsp_valid), (prev_owner == 1) ? 32'h2 : 32'h1);
        checkOutput("sat_rsp_data", 32'(bus.rsp_data), 32'(prev_data));
      end else begin
        checkOutput("sat_rsp_none", 32'(bus.rsp_valid), 32'h0);
      end
      gwe   = (g == 1) ? we1 : we0;
      gaddr = (g == 1) ? a1 : a0;
      checkOutput("sat_rd_en", 32'(mem_rd_en), 32'(!gwe));
      checkOutput("sat_wr_en", 32'(mem_wr_en), 32'(gwe));
      if (gwe) checkOutput("sat_wr_addr", 32'(mem_wr_addr), 32'(gaddr));
      else     checkOutput("sat_rd_addr", 32'(mem_rd_addr), 32'(gaddr));
      prev_rd    = !gwe;
      prev_owner = g;
      prev_data  = pat(gaddr);
    end
    applyStimulus(1'b0, 2'b00, 2'b00, 10'h0, 10'h0, 24'h0, 24'h0);
    if (prev_rd) checkOutput("sat_tail_valid", 32'(bus.rsp_valid), (prev_owner == 1) ? 32'h2 : 32'h1);
    else         checkOutput("sat_tail_none", 32'(bus.rsp_valid), 32'h0);

    // Single requester 1 streaming reads 0x000..0x007
    for (int i = 0; i < 9; i++) begin
      if (i < 8) applyStimulus(1'b0, 2'b10, 2'b00, 10'h0, 10'(i), 24'h0, 24'h0);
      else       applyStimulus(1'b0, 2'b00, 2'b00, 10'h0, 10'h0, 24'h0, 24'h0);
      if (i < 8) checkOutput("single_ready", 32'(bus.req_ready), 32'h2);
      if (i > 0) begin
        checkOutput("single_rsp_valid", 32'(bus.rsp_valid), 32'h2);
        checkOutput("single_rsp_data", 32'(bus.rsp_data), 32'(pat(10'(i - 1))));
      end
    end

    // Reset right after an accepted read drops its response
    applyStimulus(1'b0, 2'b01, 2'b00, 10'h005, 10'h0, 24'h0, 24'h0);
    checkOutput("mid_ready", 32'(bus.req_ready), 32'h1);
    applyStimulus(1'b1, 2'b00, 2'b00, 10'h0, 10'h0, 24'h0, 24'h0);
    checkOutput("mid_rsp_dropped", 32'(bus.rsp_valid), 32'h0);
    applyStimulus(1'b1, 2'b11, 2'b11, 10'h002, 10'h003, 24'h0, 24'h0);
    checkOutput("mid_rst_ready", 32'(bus.req_ready), 32'h0);
    checkOutput("mid_rst_wr_en", 32'(mem_wr_en), 32'h0);
    checkOutput("mid_rst_rsp", 32'(bus.rsp_valid), 32'h0);
    applyStimulus(1'b0, 2'b11, 2'b00, 10'h002, 10'h003, 24'h0, 24'h0);
    checkOutput("mid_post_ready", 32'(bus.req_ready), 32'h1);
    applyStimulus(1'b0, 2'b10, 2'b00, 10'h002, 10'h003, 24'h0, 24'h0);
    checkOutput("mid_post_ready1", 32'(bus.req_ready), 32'h2);
    checkOutput("mid_post_rsp0", 32'(bus.rsp_valid), 32'h1);
    checkOutput("mid_post_data0", 32'(bus.rsp_data), 32'h020202);
    applyStimulus(1'b0, 2'b00, 2'b00, 10'h0, 10'h0, 24'h0, 24'h0);
    checkOutput("mid_post_rsp1", 32'(bus.rsp_valid), 32'h2);
    checkOutput("mid_post_data1", 32'(bus.rsp_data), 32'h030303);

    // Idle: enables low, read data held, then an immediate grant
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b0, 2'b00, 2'b00, 10'h0, 10'h0, 24'h0, 24'h0);
      checkOutput("idle_rd_en", 32'(mem_rd_en), 32'h0);
      checkOutput("idle_wr_en", 32'(mem_wr_en), 32'h0);
      checkOutput("idle_rsp_valid", 32'(bus.rsp_valid), 32'h0);
      checkOutput("idle_rsp_data", 32'(bus.rsp_data), 32'h030303);
    end
    applyStimulus(1'b0, 2'b01, 2'b00, 10'h009, 10'h0, 24'h0, 24'h0);
    checkOutput("wake_ready", 32'(bus.req_ready), 32'h1);
    checkOutput("wake_rd_en", 32'(mem_rd_en), 32'h1);
    checkOutput("wake_rd_addr", 32'(mem_rd_addr), 32'h009);
    applyStimulus(1'b0, 2'b00, 2'b00, 10'h0, 10'h0, 24'h0, 24'h0);
    checkOutput("wake_rsp_valid", 32'(bus.rsp_valid), 32'h1);
    checkOutput("wake_rsp_data", 32'(bus.rsp_data), 32'h090909);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
